// File: rtl/mux_stream_sel.sv
// N-channel stream multiplexer with a one-word registered output stage.
// Supports a fixed-select mode and a round-robin mode, both using valid/ready handshakes.
module mux_stream_sel #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   s,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_ch
);

    logic [SEL_W-1:0] rr_ptr_r;
    logic             load_en_s;
    logic             grant_vld_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [WIDTH-1:0] grant_data_s;
    logic             xfer_s;
    logic [SEL_W:0]   rr_pick_s;

    // Round-robin pick: {found, index} of the first valid channel after ptr, wrapping at N.
    function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] v, input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0] res;
        int             idx;
        res = {(SEL_W+1){1'b0}};
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!res[SEL_W] && v[idx]) begin
                res = {1'b1, SEL_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign load_en_s = !out_valid || out_ready;
    assign rr_pick_s = rr_pick(in_valid, rr_ptr_r);
    assign xfer_s    = load_en_s && grant_vld_s;

    // Grant selection; an out-of-range select in fixed mode matches no channel.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {SEL_W{1'b0}};
        if (mode == 1'b0) begin
            for (int i = 0; i < N; i++) begin
                if ((s == SEL_W'(i)) && in_valid[i]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SEL_W'(i);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            grant_vld_s = rr_pick_s[SEL_W];
            grant_idx_s = rr_pick_s[SEL_W-1:0];
        end
    end

    // Data mux for the granted channel and one-hot ready back to the producers.
    always_comb begin
        grant_data_s = {WIDTH{1'b0}};
        in_ready     = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant_idx_s == SEL_W'(i)) begin
                grant_data_s = in_data[i*WIDTH +: WIDTH];
                in_ready[i]  = xfer_s && !rst;
            end else begin
                in_ready[i]  = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
            out_ch    <= {SEL_W{1'b0}};
            rr_ptr_r  <= SEL_W'(N - 1);
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= grant_data_s;
            out_ch    <= grant_idx_s;
            rr_ptr_r  <= grant_idx_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_mux_stream_sel.sv
// Bench for mux_stream_sel: a 4-channel and a 3-channel instance share stimulus and are
// checked every cycle against a queue-free behavioural model, plus directed literal checks.
module tb_mux_stream_sel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  in_valid = 4'hF;
    logic        mode = 1'b0;
    logic [1:0]  s = 2'd0;
    logic        out_ready = 1'b0;

    logic [3:0]  in_ready4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic [1:0]  out_ch4;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_ch3;

    int checks = 0;
    int errors = 0;

    mux_stream_sel #(.WIDTH(8), .N(4), .SEL_W(2)) u4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .mode(mode), .s(s), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_ch(out_ch4)
    );

    mux_stream_sel #(.WIDTH(8), .N(3), .SEL_W(2)) u3 (
        .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready3),
        .mode(mode), .s(s), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready), .out_ch(out_ch3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Behavioural model: state is what the output register must hold after each edge.
    logic       m_valid [2] = '{1'b0, 1'b0};
    logic [7:0] m_data  [2] = '{8'h00, 8'h00};
    int         m_ch    [2] = '{0, 0};
    int         m_ptr   [2] = '{3, 2};

    // Per-cycle comparison against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        int          n;
        int          g;
        int          idx;
        logic [31:0] exp_rdy;
        logic [31:0] act_rdy;
        logic [31:0] act_v;
        logic [31:0] act_d;
        logic [31:0] act_c;
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 4 : 3;
            g = -1;
            if (mode == 1'b0) begin
                if (int'(s) < n && in_valid[s]) g = int'(s);
            end else begin
                for (int j = 1; j <= n; j++) begin
                    idx = (m_ptr[k] + j) % n;
                    if (g < 0 && in_valid[idx]) g = idx;
                end
            end
            exp_rdy = ((!m_valid[k] || out_ready) && g >= 0 && !rst) ? (32'd1 << g) : 32'd0;
            act_rdy = (k == 0) ? {28'd0, in_ready4} : {29'd0, in_ready3};
            act_v   = (k == 0) ? {31'd0, out_valid4} : {31'd0, out_valid3};
            act_d   = (k == 0) ? {24'd0, out_data4} : {24'd0, out_data3};
            act_c   = (k == 0) ? {30'd0, out_ch4} : {30'd0, out_ch3};
            chk($sformatf("model_in_ready_n%0d", n), act_rdy, exp_rdy);
            chk($sformatf("model_out_valid_n%0d", n), act_v, {31'd0, m_valid[k]});
            chk($sformatf("model_out_data_n%0d", n), act_d, {24'd0, m_data[k]});
            chk($sformatf("model_out_ch_n%0d", n), act_c, m_ch[k]);
            if (rst) begin
                m_valid[k] = 1'b0;
                m_data[k]  = 8'h00;
                m_ch[k]    = 0;
                m_ptr[k]   = n - 1;
            end else if (exp_rdy != 32'd0) begin
                m_valid[k] = 1'b1;
                m_data[k]  = in_data[g*8 +: 8];
                m_ch[k]    = g;
                m_ptr[k]   = g;
            end else if (m_valid[k] && out_ready) begin
                m_valid[k] = 1'b0;
            end
        end
    end

    initial begin
        // Reset held two clocks with every channel valid.
        tick();
        tick();
        at_neg();
        chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        chk("rst_out_data", {24'd0, out_data4}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch4}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready4}, 32'd0);

        // Fixed select of channel 2.
        tick();
        rst = 1'b0; mode = 1'b0; s = 2'd2; in_valid = 4'b0100;
        in_data = 32'h00A5_0000; out_ready = 1'b1;
        at_neg();
        chk("fix_in_ready", {28'd0, in_ready4}, 32'h4);
        tick();
        in_valid = 4'b0000;
        at_neg();
        chk("fix_out_valid", {31'd0, out_valid4}, 32'd1);
        chk("fix_out_data", {24'd0, out_data4}, 32'hA5);
        chk("fix_out_ch", {30'd0, out_ch4}, 32'd2);

        // Round-robin from reset with all channels valid.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; in_data = 32'h1312_1110;
        at_neg();
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("rr_out_ch", {30'd0, out_ch4}, i % 4);
            chk("rr_out_data", {24'd0, out_data4}, 32'h10 + (i % 4));
        end

        // Backpressure with 8'h11 held, then release with no bubble.
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("bp_out_data", {24'd0, out_data4}, 32'h11);
            chk("bp_in_ready", {28'd0, in_ready4}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        at_neg();
        chk("bp_release_in_ready", {28'd0, in_ready4}, 32'h4);
        tick();
        at_neg();
        chk("bp_next_data", {24'd0, out_data4}, 32'h12);
        chk("bp_next_valid", {31'd0, out_valid4}, 32'd1);

        // Out-of-range select on the 3-channel instance.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b0; s = 2'd3; in_valid = 4'hF; in_data = 32'h4433_2211;
        at_neg();
        chk("oor_in_ready", {29'd0, in_ready3}, 32'd0);
        tick();
        at_neg();
        chk("oor_out_valid", {31'd0, out_valid3}, 32'd0);
        tick();
        s = 2'd1;
        tick();
        at_neg();
        chk("oor_s1_valid", {31'd0, out_valid3}, 32'd1);
        chk("oor_s1_ch", {30'd0, out_ch3}, 32'd1);
        chk("oor_s1_data", {24'd0, out_data3}, 32'h22);

        // Reset mid-stream, round-robin restarts at channel 0.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1;
        at_neg();
        chk("mid_rst_valid", {31'd0, out_valid4}, 32'd0);
        tick();
        at_neg();
        chk("mid_rst_ch", {30'd0, out_ch4}, 32'd0);

        // Randomized traffic, checked entirely by the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst       = ($urandom_range(0, 63) == 0);
            mode      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) s = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        at_neg();
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
